// File: rtl/spike_rate_encoder.sv
// Rate-codes 8 excitatory + 8 inhibitory intensities into spike trains via phase accumulators.
// Optional build macro SPIKE_ENC_REFRACT_EN adds a 1-cycle per-channel refractory period.
module spike_rate_encoder #(
  parameter int NUM_CH = 8,
  parameter int RATE_W = 8,
  parameter int WINDOW = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [NUM_CH*RATE_W-1:0] i_rate_e,
  input  logic [NUM_CH*RATE_W-1:0] i_rate_i,
  output logic [NUM_CH-1:0]        o_excitatory,
  output logic [NUM_CH-1:0]        o_inhibitory,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int CNT_W = $clog2(WINDOW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [NUM_CH*RATE_W-1:0]   rate_e_q, rate_e_d;
  logic [NUM_CH*RATE_W-1:0]   rate_i_q, rate_i_d;
  logic [NUM_CH*RATE_W-1:0]   acc_e_q, acc_e_d;
  logic [NUM_CH*RATE_W-1:0]   acc_i_q, acc_i_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_CH-1:0]          spk_e_q, spk_e_d;
  logic [NUM_CH-1:0]          spk_i_q, spk_i_d;
  logic [RATE_W:0]            sum_e, sum_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rate_e_q <= '0;
      rate_i_q <= '0;
      acc_e_q  <= '0;
      acc_i_q  <= '0;
      cnt_q    <= '0;
      spk_e_q  <= '0;
      spk_i_q  <= '0;
    end else begin
      state_q  <= state_d;
      rate_e_q <= rate_e_d;
      rate_i_q <= rate_i_d;
      acc_e_q  <= acc_e_d;
      acc_i_q  <= acc_i_d;
      cnt_q    <= cnt_d;
      spk_e_q  <= spk_e_d;
      spk_i_q  <= spk_i_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rate_e_d = rate_e_q;
    rate_i_d = rate_i_q;
    acc_e_d  = acc_e_q;
    acc_i_d  = acc_i_q;
    cnt_d    = cnt_q;
    spk_e_d  = spk_e_q;
    spk_i_d  = spk_i_q;
    sum_e    = '0;
    sum_i    = '0;

    case (state_q)
      S_IDLE: begin
        spk_e_d = '0;
        spk_i_d = '0;
        if (i_start) begin
          rate_e_d = i_rate_e;
          rate_i_d = i_rate_i;
          acc_e_d  = '0;
          acc_i_d  = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
          sum_e = {1'b0, acc_e_q[n*RATE_W +: RATE_W]} + {1'b0, rate_e_q[n*RATE_W +: RATE_W]};
          sum_i = {1'b0, acc_i_q[n*RATE_W +: RATE_W]} + {1'b0, rate_i_q[n*RATE_W +: RATE_W]};
          acc_e_d[n*RATE_W +: RATE_W] = sum_e[RATE_W-1:0];
          acc_i_d[n*RATE_W +: RATE_W] = sum_i[RATE_W-1:0];
`ifdef SPIKE_ENC_REFRACT_EN
          // The previous spike bit doubles as the refractory flag; it is 0 in IDLE, so E0 clears it.
          spk_e_d[n] = sum_e[RATE_W] & ~spk_e_q[n];
          spk_i_d[n] = sum_i[RATE_W] & ~spk_i_q[n];
`else
          spk_e_d[n] = sum_e[RATE_W];
          spk_i_d[n] = sum_i[RATE_W];
`endif
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WINDOW - 1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        spk_e_d = '0;
        spk_i_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_excitatory = spk_e_q;
  assign o_inhibitory = spk_i_q;
  assign o_busy       = (state_q == S_RUN);
  assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder: randomized rates against a floor-arithmetic spike model.
// Honours SPIKE_ENC_REFRACT_EN so the same bench checks either build.
module tb_spike_rate_encoder;

  localparam int W = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [63:0] i_rate_e;
  logic [63:0] i_rate_i;
  logic [7:0]  o_excitatory;
  logic [7:0]  o_inhibitory;
  logic        o_busy;
  logic        o_done;

  int tests = 0;
  int fails = 0;

  int cnt_e [8];
  int cnt_i [8];
  int busy_n;
  int done_n;
  logic done_spk0;

  always #5 clk = ~clk;

  spike_rate_encoder #(.NUM_CH(8), .RATE_W(8), .WINDOW(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_rate_e     (i_rate_e),
    .i_rate_i     (i_rate_i),
    .o_excitatory (o_excitatory),
    .o_inhibitory (o_inhibitory),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Carry at step k of an accumulator starting at 0: floor(k*r/256) - floor((k-1)*r/256).
  function automatic logic [7:0] raw_spk(input logic [63:0] rates, input int k);
    logic [7:0] s;
    int r;
    s = '0;
    for (int n = 0; n < 8; n++) begin
      r = int'(rates[n*8 +: 8]);
      s[n] = ((k * r) / 256) != (((k - 1) * r) / 256);
    end
    return s;
  endfunction

  function automatic int exp_count(input int r);
`ifdef SPIKE_ENC_REFRACT_EN
    int c;
    bit prev;
    bit s;
    c = 0;
    prev = 1'b0;
    for (int k = 1; k <= W; k++) begin
      s = (((k * r) / 256) != (((k - 1) * r) / 256)) && !prev;
      c += int'(s);
      prev = s;
    end
    return c;
`else
    return (W * r) / 256;
`endif
  endfunction

  task automatic start_window(input logic [63:0] re, input logic [63:0] ri, input logic hold);
    i_rate_e = re;
    i_rate_i = ri;
    i_start  = 1'b1;
    tick();
    i_start  = hold;
    tests++;
    if (o_busy !== 1'b1) begin
      fails++;
      $display("FAIL start_busy: got %b expected 1", o_busy);
    end
    tests++;
    if ({o_inhibitory, o_excitatory} !== 16'h0000) begin
      fails++;
      $display("FAIL start_spikes: got %h expected 0000", {o_inhibitory, o_excitatory});
    end
  endtask

  // Runs steps E1..EW then the DONE->IDLE edge; a nonzero mid pulses start and scrambles rates at that step.
  task automatic run_steps(input logic [63:0] re, input logic [63:0] ri, input int mid);
    logic [7:0] pe, pi, xe, xi;
    pe = '0;
    pi = '0;
    busy_n = 1;
    done_n = 0;
    done_spk0 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      cnt_e[n] = 0;
      cnt_i[n] = 0;
    end
    for (int k = 1; k <= W; k++) begin
      if (k == mid) begin
        i_start  = 1'b1;
        i_rate_e = rand64();
        i_rate_i = rand64();
      end
      tick();
      if (k == mid) i_start = 1'b0;
      xe = raw_spk(re, k);
      xi = raw_spk(ri, k);
`ifdef SPIKE_ENC_REFRACT_EN
      xe = xe & ~pe;
      xi = xi & ~pi;
`endif
      pe = xe;
      pi = xi;
      tests++;
      if ({o_inhibitory, o_excitatory} !== {xi, xe}) begin
        fails++;
        $display("FAIL spikes step %0d: got %h expected %h", k, {o_inhibitory, o_excitatory}, {xi, xe});
      end
      tests++;
      if (o_busy !== 1'(k < W)) begin
        fails++;
        $display("FAIL busy step %0d: got %b expected %b", k, o_busy, (k < W));
      end
      tests++;
      if (o_done !== 1'(k == W)) begin
        fails++;
        $display("FAIL done step %0d: got %b expected %b", k, o_done, (k == W));
      end
      for (int n = 0; n < 8; n++) begin
        cnt_e[n] += int'(o_excitatory[n]);
        cnt_i[n] += int'(o_inhibitory[n]);
      end
      busy_n += int'(o_busy);
      done_n += int'(o_done);
      if (o_done === 1'b1) done_spk0 = o_excitatory[0];
    end
    tick();
    tests++;
    if ({o_busy, o_done, o_inhibitory, o_excitatory} !== 18'h0) begin
      fails++;
      $display("FAIL idle_after_done: got busy=%b done=%b spk=%h expected all 0",
               o_busy, o_done, {o_inhibitory, o_excitatory});
    end
  endtask

  task automatic check_counts(input logic [63:0] re, input logic [63:0] ri, input string tag);
    for (int n = 0; n < 8; n++) begin
      tests++;
      if (cnt_e[n] !== exp_count(int'(re[n*8 +: 8]))) begin
        fails++;
        $display("FAIL %s count_e ch%0d: got %0d expected %0d", tag, n, cnt_e[n], exp_count(int'(re[n*8 +: 8])));
      end
      tests++;
      if (cnt_i[n] !== exp_count(int'(ri[n*8 +: 8]))) begin
        fails++;
        $display("FAIL %s count_i ch%0d: got %0d expected %0d", tag, n, cnt_i[n], exp_count(int'(ri[n*8 +: 8])));
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    i_start  = 1'b0;
    i_rate_e = '0;
    i_rate_i = '0;
    tick();
    tick();
    tests++;
    if ({o_busy, o_done, o_inhibitory, o_excitatory} !== 18'h0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b spk=%h expected all 0",
               o_busy, o_done, {o_inhibitory, o_excitatory});
    end
    reset = 1'b1;
    tick();
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_hold: got busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_exact_count();
    logic [63:0] re, ri;
    re = {8'd37, 8'd255, 8'd200, 8'd128, 8'd64, 8'd8, 8'd1, 8'd0};
    ri = {8{8'd3}};
    start_window(re, ri, 1'b0);
    run_steps(re, ri, 0);
    check_counts(re, ri, "exact");
  endtask

  task automatic test_pattern_128();
    logic [63:0] re, ri;
    re = rand64();
    re[7:0] = 8'd128;
    ri = rand64();
    start_window(re, ri, 1'b0);
    run_steps(re, ri, 0);
    tests++;
    if (cnt_e[0] !== 128) begin
      fails++;
      $display("FAIL p128_count: got %0d expected 128", cnt_e[0]);
    end
    tests++;
    if (busy_n !== W) begin
      fails++;
      $display("FAIL p128_busy_cycles: got %0d expected %0d", busy_n, W);
    end
    tests++;
    if (done_n !== 1) begin
      fails++;
      $display("FAIL p128_done_pulses: got %0d expected 1", done_n);
    end
    tests++;
    if (done_spk0 !== 1'b1) begin
      fails++;
      $display("FAIL p128_done_with_spike: got %b expected 1", done_spk0);
    end
  endtask

  task automatic test_ignore_busy();
    logic [63:0] re, ri;
    re = rand64();
    ri = rand64();
    start_window(re, ri, 1'b0);
    run_steps(re, ri, 100);
    check_counts(re, ri, "ignore");
  endtask

  task automatic test_back_to_back();
    logic [63:0] re, ri;
    re = rand64();
    ri = rand64();
    start_window(re, ri, 1'b1);
    run_steps(re, ri, 0);
    check_counts(re, ri, "b2b_first");
    tick();
    tests++;
    if (o_busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart: got busy=%b expected 1", o_busy);
    end
    i_start = 1'b0;
    run_steps(re, ri, 0);
    check_counts(re, ri, "b2b_second");
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] re;
    re = {8{8'hFF}};
    start_window(re, re, 1'b0);
    for (int k = 1; k < 50; k++) tick();
    reset = 1'b0;
    tick();
    tests++;
    if ({o_busy, o_done, o_inhibitory, o_excitatory} !== 18'h0) begin
      fails++;
      $display("FAIL midrun_reset: got busy=%b done=%b spk=%h expected all 0",
               o_busy, o_done, {o_inhibitory, o_excitatory});
    end
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if ({o_busy, o_done, o_inhibitory, o_excitatory} !== 18'h0) begin
      fails++;
      $display("FAIL midrun_reset_idle: got busy=%b done=%b spk=%h expected all 0",
               o_busy, o_done, {o_inhibitory, o_excitatory});
    end
    start_window(re, re, 1'b0);
    run_steps(re, re, 0);
    check_counts(re, re, "after_reset");
  endtask

  task automatic test_rate255();
    logic [63:0] re, ri;
    re = rand64();
    re[7:0] = 8'd255;
    ri = rand64();
    start_window(re, ri, 1'b0);
    run_steps(re, ri, 0);
    tests++;
`ifdef SPIKE_ENC_REFRACT_EN
    if (cnt_e[0] !== 128) begin
      fails++;
      $display("FAIL r255_count: got %0d expected 128", cnt_e[0]);
    end
`else
    if (cnt_e[0] !== 255) begin
      fails++;
      $display("FAIL r255_count: got %0d expected 255", cnt_e[0]);
    end
`endif
  endtask

  task automatic test_random_windows();
    logic [63:0] re, ri;
    for (int t = 0; t < 3; t++) begin
      re = rand64();
      ri = rand64();
      start_window(re, ri, 1'b0);
      run_steps(re, ri, 0);
      check_counts(re, ri, "random");
    end
  endtask

  initial begin
    test_reset();
    test_exact_count();
    test_pattern_128();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_rate255();
    test_random_windows();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

- Rate-codes per-channel intensity values into spike trains for one neuron's synaptic inputs.
- Has 8 excitatory and 8 inhibitory channels.
- Each channel uses a deterministic phase accumulator, so a presentation window of `WINDOW` cycles yields a spike count set exactly by the programmed rate.
- Sits upstream of the neuron array: `o_excitatory` and `o_inhibitory` drive the neuron's `i_excitatory` and `i_inhibitory` inputs bit-for-bit.

## Interface
- `NUM_CH`, 8: channels per polarity.
- `RATE_W`, 8: rate/accumulator width; accumulator modulus is 2^`RATE_W`.
- `WINDOW`, 256: RUN length in cycles; must be ≥ 2.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-low; acts on the rising edge of `clk` while low.
- `i_start` input 1: request a presentation; sampled only in IDLE.
- `i_rate_e` input `NUM_CH`*`RATE_W`: packed excitatory rates; channel n occupies bits [n*`RATE_W` +: `RATE_W`].
- `i_rate_i` input `NUM_CH`*`RATE_W`: packed inhibitory rates, same packing.
- `o_excitatory` output `NUM_CH`: registered excitatory spikes, one bit per channel.
- `o_inhibitory` output `NUM_CH`: registered inhibitory spikes.
- `o_busy` output 1: high while in RUN.
- `o_done` output 1: one-cycle pulse, high while in DONE.

## Operation
- Reset (`reset` low at an edge), from any state including mid-RUN:
  - state <= IDLE;
  - all accumulators, latched rates and the window counter <= 0;
  - `o_excitatory`, `o_inhibitory`, `o_busy`, `o_done` <= 0.
- IDLE:
  - If `i_start` is high at an edge: latch both rate buses, clear all accumulators and the counter, go to RUN.
  - Otherwise hold, spike outputs 0.
- RUN, per edge:
  - Per channel: {carry, acc} <= acc + rate, computed in `RATE_W`+1 bits.
  - Spike bit <= carry.
  - Counter increments.
  - On the edge where counter == `WINDOW`-1, go to DONE.
  - `i_start` and changes on the rate buses are ignored; only the latched values are used.
- DONE: lasts one cycle. On the next edge:
  - spike outputs <= 0;
  - go to IDLE.
  - An `i_start` seen on that edge is ignored; a new start is accepted from the first IDLE cycle onward.
- Spike count: with acc starting at 0, the spikes over W accumulate steps equal floor(W*r / 2^`RATE_W`).
  - With `WINDOW` = 2^`RATE_W`, each channel emits exactly r spikes.
  - r = 0 gives no spikes.
  - r = 2^`RATE_W`-1 spikes on every step except the first.
- Excitatory and inhibitory channels are independent and identical in behaviour. The spike count in Configuration applies per channel.

## Timing
- Let E0 be the edge that accepts `i_start`.
- Edges E1..E`WINDOW` are the accumulate steps.
- The spike result of step k is visible on the outputs during the cycle after Ek, for exactly `WINDOW` consecutive cycles.
- `o_busy` is high during the cycles after E0..E(`WINDOW`-1).
- `o_done` is high during the single cycle after E`WINDOW`; this is the same cycle the step-`WINDOW` spikes are visible.
- Start-to-first-spike latency is 2 edges.
- Back-to-back presentations: `i_start` held high gives a new E0 at E(`WINDOW`+2), i.e. one idle cycle with outputs 0 between windows.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SPIKE_ENC_REFRACT_EN`.
- Defined: each channel has a 1-cycle refractory period.
  - If a channel's spike bit was 1 in the previous cycle, its spike bit is forced to 0 this step.
  - The accumulator still updates and the carry is discarded.
  - The refractory flag clears on reset and on E0.
- Undefined: no refractory logic; the spike bit equals the carry on every step.

## Test plan
- Reset mid-RUN:
  - Stimulus: start with all rates 8'hFF; hold `reset` low at cycle 50; release.
  - Response: at the next edge all outputs are 0 and state is IDLE; a fresh start then completes a full 256-cycle window.
- Exact count:
  - Stimulus: `WINDOW` = 256; excitatory rates ch0..ch7 = 0, 1, 8, 64, 128, 200, 255, 37; inhibitory = 3 on all channels.
  - Response: excitatory counts 0, 1, 8, 64, 128, 200, 255, 37; inhibitory count 3 per channel.
- Pattern and timing, rate 128 on ch0:
  - Response: ch0 spikes on even steps 2, 4, …, 256, 128 total.
  - `o_busy` is high for exactly 256 cycles.
  - `o_done` pulses once, coincident with the step-256 spike.
- Start/rate ignored while busy:
  - Stimulus: pulse `i_start` and change all rates mid-RUN.
  - Response: no restart and counts unchanged.
  - A held `i_start` restarts only after the one-cycle idle gap.
- Rate 255, ch0:
  - Without `SPIKE_ENC_REFRACT_EN`: 255 spikes, on steps 2..256.
  - With `SPIKE_ENC_REFRACT_EN`: 128 spikes, on steps 2, 4, …, 256.
  - Either build: no spike on step 1.
